// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the writeback stage: ALU opcode encodings, flag bit
// positions and default datapath geometry.
package regfile_writeback_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int NUM_GPR_DEF = 32;
  localparam int ADDR_W_DEF  = 5;

  localparam logic [4:0] OP_MOV_TO_REG  = 5'b00000;
  localparam logic [4:0] OP_MOVE        = 5'b00001;
  localparam logic [4:0] OP_ADD         = 5'b00010;
  localparam logic [4:0] OP_SUB         = 5'b00011;
  localparam logic [4:0] OP_MUL         = 5'b00100;
  localparam logic [4:0] OP_LOGIC_FIRST = 5'b00101;
  localparam logic [4:0] OP_LOGIC_LAST  = 5'b01011;

  localparam int FLAG_SIGN     = 3;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_CARRY    = 0;

  // Every defined opcode writes a GPR; 01100..11111 are undefined.
  function automatic logic op_writes_gpr(input logic [4:0] op);
    logic hit;
    hit = 1'b0;
    case (op) inside
      OP_MOV_TO_REG, OP_MOVE, OP_ADD, OP_SUB, OP_MUL: hit = 1'b1;
      [OP_LOGIC_FIRST:OP_LOGIC_LAST]:                 hit = 1'b1;
      default:                                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// ALU-to-writeback handshake bundle; the ALU drives the master side.
interface regfile_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_opcode;
  logic [ADDR_W-1:0] wb_rdst;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_special;
  logic [3:0]        alu_flags;

  modport master (
    output wb_valid, wb_opcode, wb_rdst, alu_result, alu_special, alu_flags,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_opcode, wb_rdst, alu_result, alu_special, alu_flags,
    output wb_ready
  );
endinterface

// File: rtl/regfile_writeback_gpr_array.sv
// General-purpose register array: one synchronous write port, two
// asynchronous read ports, asynchronous clear.
module regfile_writeback_gpr_array #(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_q [NUM_GPR];
  logic [DATA_W-1:0] mem_d [NUM_GPR];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPR; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: one-entry pending slot, commit into GPRs/sgpr/flags, bypassed
// read ports. Optional macro ILLEGAL_OP_TRAP_EN adds a sticky illegal_trap output.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_GPR = NUM_GPR_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_writeback_if.slave  wb,
  input  logic                hold,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic [DATA_W-1:0]   sgpr,
  output logic [3:0]          flags,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                illegal_trap,
`endif
  output logic [15:0]         instr_retired
);

  logic              p_valid_q, p_valid_d;
  logic [4:0]        p_opcode_q, p_opcode_d;
  logic [ADDR_W-1:0] p_rdst_q, p_rdst_d;
  logic [DATA_W-1:0] p_result_q, p_result_d;
  logic [DATA_W-1:0] p_special_q, p_special_d;
  logic [3:0]        p_flags_q, p_flags_d;

  logic [DATA_W-1:0] sgpr_q, sgpr_d;
  logic [3:0]        flags_q, flags_d;
  logic [15:0]       retired_q, retired_d;
  logic              trap_q, trap_d;

  logic              frozen, ready, accept, commit, p_writes;
  logic [DATA_W-1:0] p_wdata, gpr_rdata1, gpr_rdata2;

`ifdef ILLEGAL_OP_TRAP_EN
  assign frozen       = trap_q;
  assign illegal_trap = trap_q;
`else
  assign frozen       = 1'b0;
`endif

  assign ready       = (!p_valid_q || !hold) && !frozen;
  assign wb.wb_ready = ready;
  assign accept      = wb.wb_valid && ready;
  assign commit      = p_valid_q && !hold && !frozen;
  assign p_writes    = op_writes_gpr(p_opcode_q);
  // mov_to_reg takes sgpr as it stands at commit, not at accept.
  assign p_wdata     = (p_opcode_q == OP_MOV_TO_REG) ? sgpr_q : p_result_q;

  always_comb begin
    p_valid_d   = accept || (p_valid_q && !commit);
    p_opcode_d  = p_opcode_q;
    p_rdst_d    = p_rdst_q;
    p_result_d  = p_result_q;
    p_special_d = p_special_q;
    p_flags_d   = p_flags_q;
    sgpr_d      = sgpr_q;
    flags_d     = flags_q;
    retired_d   = retired_q;
    trap_d      = trap_q;
    if (accept) begin
      p_opcode_d  = wb.wb_opcode;
      p_rdst_d    = wb.wb_rdst;
      p_result_d  = wb.alu_result;
      p_special_d = wb.alu_special;
      p_flags_d   = wb.alu_flags;
    end
    if (commit) begin
      if (p_writes) begin
        retired_d = retired_q + 16'd1;
        if (p_opcode_q == OP_MUL) sgpr_d = p_special_q;
        if (p_opcode_q != OP_MOV_TO_REG) begin
          flags_d[FLAG_SIGN]     = p_flags_q[FLAG_SIGN];
          flags_d[FLAG_ZERO]     = p_flags_q[FLAG_ZERO];
          flags_d[FLAG_OVERFLOW] = p_flags_q[FLAG_OVERFLOW];
          flags_d[FLAG_CARRY]    = p_flags_q[FLAG_CARRY];
        end
      end else begin
`ifdef ILLEGAL_OP_TRAP_EN
        trap_d = 1'b1;
`else
        retired_d = retired_q + 16'd1;
`endif
      end
    end
  end

  // Control and architectural state: async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      sgpr_q    <= '0;
      flags_q   <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      p_valid_q <= p_valid_d;
      sgpr_q    <= sgpr_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  // Pending-slot payload: qualified by p_valid_q, so no reset needed
  always_ff @(posedge clk) begin
    p_opcode_q  <= p_opcode_d;
    p_rdst_q    <= p_rdst_d;
    p_result_q  <= p_result_d;
    p_special_q <= p_special_d;
    p_flags_q   <= p_flags_d;
  end

  regfile_writeback_gpr_array #(
    .DATA_W  (DATA_W),
    .NUM_GPR (NUM_GPR),
    .ADDR_W  (ADDR_W)
  ) u_gpr (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit && p_writes),
    .waddr  (p_rdst_q),
    .wdata  (p_wdata),
    .raddr1 (rd_addr1),
    .raddr2 (rd_addr2),
    .rdata1 (gpr_rdata1),
    .rdata2 (gpr_rdata2)
  );

  assign rd_data1 = (p_valid_q && p_writes && p_rdst_q == rd_addr1) ? p_wdata : gpr_rdata1;
  assign rd_data2 = (p_valid_q && p_writes && p_rdst_q == rd_addr2) ? p_wdata : gpr_rdata2;

  assign sgpr          = sgpr_q;
  assign flags         = flags_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vectors plus an architectural model
// checked every cycle. Handles builds with or without ILLEGAL_OP_TRAP_EN.
module tb_regfile_writeback;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic [DW-1:0] rd_data1, rd_data2, sgpr;
  logic [3:0]    flags;
  logic [15:0]   instr_retired;
  logic          trap_out;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) wb_if ();

  regfile_writeback #(.DATA_W(DW), .NUM_GPR(32), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb_if),
    .hold          (hold),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2),
    .sgpr          (sgpr),
    .flags         (flags),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_trap  (trap_out),
`endif
    .instr_retired (instr_retired)
  );

`ifndef ILLEGAL_OP_TRAP_EN
  assign trap_out = 1'b0;
`endif

  always #5 clk = ~clk;

  // Architectural model: register file, sgpr, flags, counter and a queue
  // holding at most one instruction that has been accepted but not retired.
  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [15:0] res;
    logic [15:0] spec;
    logic [3:0]  fl;
  } ent_t;

  logic [15:0] m_gpr [32];
  logic [15:0] m_sgpr;
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;
  logic        m_trap;
  ent_t        m_pend [$];

  function automatic logic defined_op(input logic [4:0] op);
    return op < 5'd12;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [4:0] a);
    if (m_pend.size() > 0 && defined_op(m_pend[0].op) && m_pend[0].rd == a)
      return (m_pend[0].op == 5'd0) ? m_sgpr : m_pend[0].res;
    return m_gpr[a];
  endfunction

  function automatic logic exp_ready();
    return (m_pend.size() == 0 || !hold) && !m_trap;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  initial begin
    ent_t e;
    logic take, retire;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_sgpr = '0; m_flags = '0; m_cnt = '0; m_trap = 1'b0;
        m_pend.delete();
      end else begin
        take   = exp_ready();
        retire = m_pend.size() > 0 && !hold && !m_trap;
        if (retire) begin
          e = m_pend.pop_front();
          if (defined_op(e.op)) begin
            m_gpr[e.rd] = (e.op == 5'd0) ? m_sgpr : e.res;
            if (e.op == 5'd4) m_sgpr = e.spec;
            if (e.op != 5'd0) m_flags = e.fl;
            m_cnt = m_cnt + 16'd1;
          end else begin
`ifdef ILLEGAL_OP_TRAP_EN
            m_trap = 1'b1;
`else
            m_cnt = m_cnt + 16'd1;
`endif
          end
        end
        if (wb_if.wb_valid && take) begin
          e.op = wb_if.wb_opcode; e.rd = wb_if.wb_rdst; e.res = wb_if.alu_result;
          e.spec = wb_if.alu_special; e.fl = wb_if.alu_flags;
          m_pend.push_back(e);
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_ready", {31'd0, wb_if.wb_ready}, {31'd0, exp_ready()});
        chk("m_rd1", {16'd0, rd_data1}, {16'd0, exp_rd(rd_addr1)});
        chk("m_rd2", {16'd0, rd_data2}, {16'd0, exp_rd(rd_addr2)});
        chk("m_sgpr", {16'd0, sgpr}, {16'd0, m_sgpr});
        chk("m_flags", {28'd0, flags}, {28'd0, m_flags});
        chk("m_retired", {16'd0, instr_retired}, {16'd0, m_cnt});
        chk("m_trap", {31'd0, trap_out}, {31'd0, m_trap});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd,
                       input logic [15:0] res, input logic [15:0] spec, input logic [3:0] fl);
    wb_if.wb_valid = v; wb_if.wb_opcode = op; wb_if.wb_rdst = rd;
    wb_if.alu_result = res; wb_if.alu_special = spec; wb_if.alu_flags = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] iv;
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      @(negedge clk);
      chk("reset_gpr", {16'd0, rd_data1}, 32'h0);
      tick();
    end
    @(negedge clk);
    chk("reset_sgpr", {16'd0, sgpr}, 32'h0);
    chk("reset_flags", {28'd0, flags}, 32'h0);
    chk("reset_retired", {16'd0, instr_retired}, 32'h0);
    chk("reset_ready", {31'd0, wb_if.wb_ready}, 32'h1);
    tick();

    // add r3 = 0x1234, flags 0001
    drive(1'b1, 5'd2, 5'd3, 16'h1234, 16'h0, 4'b0001); rd_addr1 = 5'd3;
    tick();
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    chk("add_bypass", {16'd0, rd_data1}, 32'h1234);
    tick();
    @(negedge clk);
    chk("add_gpr3", {16'd0, rd_data1}, 32'h1234);
    chk("add_flags", {28'd0, flags}, 32'h1);
    chk("add_retired", {16'd0, instr_retired}, 32'h1);
    tick();

    // mul r4 then back-to-back mov_to_reg r5
    drive(1'b1, 5'd4, 5'd4, 16'h0002, 16'h0001, 4'b1000);
    tick();
    drive(1'b1, 5'd0, 5'd5, 16'hDEAD, 16'hBEEF, 4'b0111);
    tick();
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    rd_addr1 = 5'd5; rd_addr2 = 5'd4;
    @(negedge clk);
    chk("mov_bypass", {16'd0, rd_data1}, 32'h0001);
    chk("mul_gpr4", {16'd0, rd_data2}, 32'h0002);
    chk("mul_sgpr", {16'd0, sgpr}, 32'h0001);
    tick();
    @(negedge clk);
    chk("mov_gpr5", {16'd0, rd_data1}, 32'h0001);
    chk("mov_flags", {28'd0, flags}, 32'h8);
    chk("mov_retired", {16'd0, instr_retired}, 32'h3);
    tick();

    // hold with empty slot: one accept, then frozen
    hold = 1'b1;
    drive(1'b1, 5'd2, 5'd6, 16'h5555, 16'h0, 4'b0010); rd_addr1 = 5'd6;
    tick();
    drive(1'b1, 5'd3, 5'd6, 16'h9999, 16'h0, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready", {31'd0, wb_if.wb_ready}, 32'h0);
      chk("hold_pending", {16'd0, rd_data1}, 32'h5555);
      chk("hold_retired", {16'd0, instr_retired}, 32'h3);
      tick();
    end
    hold = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    chk("release_ready", {31'd0, wb_if.wb_ready}, 32'h1);
    tick();
    @(negedge clk);
    chk("release_gpr6", {16'd0, rd_data1}, 32'h5555);
    chk("release_retired", {16'd0, instr_retired}, 32'h4);
    chk("release_flags", {28'd0, flags}, 32'h2);
    tick();

    // Reset while an entry is pending
    drive(1'b1, 5'd2, 5'd8, 16'h7777, 16'h0, 4'b1111); rd_addr1 = 5'd8;
    tick();
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_gpr8", {16'd0, rd_data1}, 32'h0);
    chk("rstmid_retired", {16'd0, instr_retired}, 32'h0);
    chk("rstmid_flags", {28'd0, flags}, 32'h0);
    tick();

    // 65536 back-to-back commits wrap the counter
    rd_addr1 = 5'd7;
    for (int i = 0; i < 65536; i++) begin
      iv = 16'(i);
      drive(1'b1, 5'd1, iv[4:0], iv, 16'h0, 4'b0010);
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    chk("wrap_ffff", {16'd0, instr_retired}, 32'hFFFF);
    tick();
    @(negedge clk);
    chk("wrap_zero", {16'd0, instr_retired}, 32'h0);
    chk("wrap_gpr7", {16'd0, rd_data1}, 32'hFFE7);
    tick();

    // Undefined opcode 0x1F to r7
    drive(1'b1, 5'h1F, 5'd7, 16'h0BAD, 16'h0BAD, 4'b1101);
    tick();
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    chk("undef_nobypass", {16'd0, rd_data1}, 32'hFFE7);
    tick();
    @(negedge clk);
    chk("undef_gpr7", {16'd0, rd_data1}, 32'hFFE7);
    chk("undef_flags", {28'd0, flags}, 32'h2);
    chk("undef_sgpr", {16'd0, sgpr}, 32'h0);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("undef_trap", {31'd0, trap_out}, 32'h1);
    chk("undef_ready", {31'd0, wb_if.wb_ready}, 32'h0);
    chk("undef_retired", {16'd0, instr_retired}, 32'h0);
`else
    chk("undef_ready", {31'd0, wb_if.wb_ready}, 32'h1);
    chk("undef_retired", {16'd0, instr_retired}, 32'h1);
`endif
    tick();

    // Attempt another instruction afterwards
    drive(1'b1, 5'd2, 5'd7, 16'h4321, 16'h0, 4'b0100);
    tick();
    drive(1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 4'h0);
    tick();
    @(negedge clk);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("trap_frozen_gpr7", {16'd0, rd_data1}, 32'hFFE7);
`else
    chk("post_gpr7", {16'd0, rd_data1}, 32'h4321);
    chk("post_retired", {16'd0, instr_retired}, 32'h2);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
